// File: rtl/dpram_pkg.sv
// Shared constants and the clear-sequencer state type for the true dual-port RAM.
package dpram_pkg;

  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_t;

endpackage

// File: rtl/dpram_clear_seq.sv
// Clear sequencer: walks every address once, zeroing one word per cycle, and
// flags busy while doing so. Its write is muxed onto RAM port A by the top.
module dpram_clear_seq
  import dpram_pkg::*;
#(
  parameter int ADDR_WIDTH     = 6,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clear,
  output logic                  busy,
  output logic                  clr_we,
  output logic [ADDR_WIDTH-1:0] clr_addr,
  output clr_state_t            state
);

  localparam clr_state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= RESET_STATE;
      clr_addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (clear) begin
            state    <= CLEAR;
            clr_addr <= '0;
          end
        end
        CLEAR: begin
          // The counter wraps to 0 on the last word, ready for the next request.
          clr_addr <= clr_addr + 1'b1;
          if (clr_addr == '1) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy   = (state == CLEAR);
  assign clr_we = (state == CLEAR);

endmodule

// File: rtl/dual_port_ram_tdp.sv
// True dual-port RAM with byte-lane writes, selectable same-port read-during-write,
// optional output register and a built-in clear sequencer on port A.
module dual_port_ram_tdp
  import dpram_pkg::*;
#(
  parameter int ADDR_WIDTH     = 6,
  parameter int DATA_WIDTH     = 8,
  parameter int BYTE_WIDTH     = 8,
  parameter int RDW_MODE       = RDW_READ_FIRST,
  parameter int OUT_REG        = 0,
  parameter int CLEAR_ON_RESET = 1,
  localparam int NB            = DATA_WIDTH / BYTE_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  en_a,
  input  logic [NB-1:0]         we_a,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [DATA_WIDTH-1:0] din_a,
  output logic [DATA_WIDTH-1:0] dout_a,
  output logic                  valid_a,
  input  logic                  en_b,
  input  logic [NB-1:0]         we_b,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [DATA_WIDTH-1:0] din_b,
  output logic [DATA_WIDTH-1:0] dout_b,
  output logic                  valid_b,
  input  logic                  clear,
  output logic                  busy,
  output logic                  collision,
  output clr_state_t            state
);

  // Handshake: an access is accepted when en_x=1 and busy=0; valid_x pulses for
  // exactly one cycle with its data, 1 (OUT_REG=0) or 2 (OUT_REG=1) cycles later.
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  clr_we;
  logic [ADDR_WIDTH-1:0] clr_addr;

  dpram_clear_seq #(
    .ADDR_WIDTH     (ADDR_WIDTH),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_clear_seq (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (clear),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr),
    .state    (state)
  );

  function automatic logic [DATA_WIDTH-1:0] lane_merge(input logic [DATA_WIDTH-1:0] old,
                                                      input logic [DATA_WIDTH-1:0] din,
                                                      input logic [NB-1:0]         we);
    lane_merge = old;
    for (int i = 0; i < NB; i++)
      if (we[i]) lane_merge[i*BYTE_WIDTH +: BYTE_WIDTH] = din[i*BYTE_WIDTH +: BYTE_WIDTH];
  endfunction

  logic                  acc_a, acc_b;
  logic [NB-1:0]         wa_we, wb_we;
  logic [ADDR_WIDTH-1:0] wa_addr;
  logic [DATA_WIDTH-1:0] wa_din;
  logic [DATA_WIDTH-1:0] rdata_a, rdata_b;

  assign acc_a = en_a & ~busy;
  assign acc_b = en_b & ~busy;

  always_comb begin
    wa_we   = acc_a ? we_a : '0;
    wa_addr = addr_a;
    wa_din  = din_a;
    wb_we   = acc_b ? we_b : '0;
    if (clr_we) begin
      wa_we   = '1;
      wa_addr = clr_addr;
      wa_din  = '0;
    end
  end

  // Port A is applied last so it owns any lane both ports write in the same cycle.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (wb_we[i]) mem[addr_b][i*BYTE_WIDTH +: BYTE_WIDTH] <= din_b[i*BYTE_WIDTH +: BYTE_WIDTH];
      if (wa_we[i]) mem[wa_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= wa_din[i*BYTE_WIDTH +: BYTE_WIDTH];
    end
  end

  // WRITE_FIRST only merges the reading port's own data; other-port writes stay invisible.
  always_comb begin
    rdata_a = mem[addr_a];
    rdata_b = mem[addr_b];
    if (RDW_MODE == RDW_WRITE_FIRST) begin
      rdata_a = lane_merge(mem[addr_a], din_a, we_a);
      rdata_b = lane_merge(mem[addr_b], din_b, we_b);
    end
  end

  logic [DATA_WIDTH-1:0] rd_a, rd_b;
  logic                  rv_a, rv_b;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_a      <= '0;
      rd_b      <= '0;
      rv_a      <= 1'b0;
      rv_b      <= 1'b0;
      collision <= 1'b0;
    end else begin
      rv_a      <= acc_a;
      rv_b      <= acc_b;
      if (acc_a) rd_a <= rdata_a;
      if (acc_b) rd_b <= rdata_b;
      collision <= acc_a & acc_b & (addr_a == addr_b) & ((|we_a) | (|we_b));
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          dout_a  <= '0;
          dout_b  <= '0;
          valid_a <= 1'b0;
          valid_b <= 1'b0;
        end else begin
          valid_a <= rv_a;
          valid_b <= rv_b;
          if (rv_a) dout_a <= rd_a;
          if (rv_b) dout_b <= rd_b;
        end
      end
    end else begin : g_no_out_reg
      assign dout_a  = rd_a;
      assign dout_b  = rd_b;
      assign valid_a = rv_a;
      assign valid_b = rv_b;
    end
  endgenerate

endmodule
